if_prefetch_queue: RTL



---
 rtl/if_prefetch_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_prefetch_queue                                            |
// | Description : Instruction-fetch front end. Owns the fetch PC, keeps one    |
// |               read outstanding on port A, buffers returned words in a      |
// |               DEPTH-entry queue drained by decode via valid/ready, and     |
// |               flushes on branch/trap/JMP redirects, discarding a read      |
// |               still in flight when the redirect arrives.                   |
// | Options     : IF_PERF_CNT_EN adds saturating stall and flush counters.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_prefetch_queue #(
  parameter int              XLEN     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_mem_read,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_resp,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_br_en,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_jmp_en,
  input  logic [XLEN-1:0] i_jmp_target,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     o_perf_stall_cnt,
  output logic [31:0]     o_perf_flush_cnt
`endif
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH = DEPTH[c_PTR_W:0];

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e               r_state;
  logic [XLEN-1:0]      r_fetch_pc;
  logic                 r_mem_read;
  logic [XLEN-1:0]      r_mem_addr;
  logic [c_PTR_W:0]     r_count;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [XLEN-1:0]      r_q_instr [DEPTH];
  logic [XLEN-1:0]      r_q_pc    [DEPTH];

  logic                 w_redirect;
  logic [XLEN-1:0]      w_sel_target;
  logic [XLEN-1:0]      w_target;
  logic [XLEN-1:0]      w_pc_inc;
  logic                 w_resp;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_pend_nx;
  logic [c_PTR_W:0]     w_count_nx;
  logic [XLEN-1:0]      w_pc_nx;
  state_e               w_state_nx;
  logic                 w_read_nx;
  logic [XLEN-1:0]      w_addr_nx;

  // Redirect source selection: branch beats trap beats jump; targets are halfword aligned.
  assign w_redirect   = i_br_en | i_trap_en | i_jmp_en;
  assign w_sel_target = i_br_en ? i_br_target : (i_trap_en ? i_trap_target : i_jmp_target);
  assign w_target     = {w_sel_target[XLEN-1:1], 1'b0};
  assign w_pc_inc     = r_fetch_pc + XLEN'(2);

  // A response only counts while a request is actually up; stale responses are ignored.
  assign w_resp    = r_mem_read & i_mem_resp;
  assign w_enq     = w_resp & (r_state == ST_FETCH) & ~w_redirect;
  assign w_deq     = o_id_valid & i_id_ready;
  assign w_pend_nx = r_mem_read & ~w_resp;

  // Next-state computation for queue occupancy, fetch PC, FSM and the read request.
  always_comb begin
    w_count_nx = r_count;
    if (w_redirect) begin
      w_count_nx = '0;
    end else if (w_enq && !w_deq) begin
      w_count_nx = r_count + 1'b1;
    end else if (!w_enq && w_deq) begin
      w_count_nx = r_count - 1'b1;
    end

    w_pc_nx = r_fetch_pc;
    if (w_redirect) begin
      w_pc_nx = w_target;
    end else if (w_enq) begin
      w_pc_nx = w_pc_inc;
    end

    w_state_nx = r_state;
    if (r_state == ST_FETCH) begin
      if (w_redirect && w_pend_nx) begin
        w_state_nx = ST_DISCARD;
      end
    end else if (w_resp) begin
      w_state_nx = ST_FETCH;
    end

    // An in-flight request keeps its address until answered, even across a redirect.
    if (w_pend_nx) begin
      w_read_nx = 1'b1;
      w_addr_nx = r_mem_addr;
    end else begin
      w_read_nx = (w_count_nx < c_DEPTH);
      w_addr_nx = w_pc_nx;
    end
  end

  // FSM, fetch PC, registered memory request and queue bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_mem_read <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_pc_nx;
      r_mem_read <= w_read_nx;
      r_mem_addr <= w_addr_nx;
      r_count    <= w_count_nx;
      if (w_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Queue storage; contents are only observed through the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_instr[r_wr_ptr] <= i_mem_rdata;
      r_q_pc[r_wr_ptr]    <= w_pc_inc;
    end
  end

  assign o_mem_read = r_mem_read;
  assign o_mem_addr = r_mem_addr;
  assign o_id_valid = (r_count != '0);
  assign o_id_instr = o_id_valid ? r_q_instr[r_rd_ptr] : '0;
  assign o_id_pc    = o_id_valid ? r_q_pc[r_rd_ptr]    : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counters for empty-queue cycles and redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_id_valid && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_stall_cnt;
  assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
